// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract arbiter slice.
package addsub_pkg;

  localparam int unsigned DEFAULT_SETTLE = 4;
  localparam int unsigned PORT_CNT       = 2;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/add32Bit.sv
// 32-bit ripple-carry adder; ovf is the carry into bit 31 xor the carry out of bit 31.
module add32Bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        co,
  output logic        ovf
);

  always_comb begin : ripple
    logic [32:0] c;
    c    = 33'(ci);
    sum  = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co  = c[32];
    ovf = c[31] ^ c[32];
  end

endmodule

// File: rtl/addsub_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; owns the last-grant pointer (resets to 1 so port 0 wins first).
module rr_arb2
  import addsub_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PORT_CNT-1:0] req,
  input  logic                advance,
  output logic [PORT_CNT-1:0] grant_c
);

  logic last_q;
  logic last_d;

  // Contention goes to the port not granted last; a lone request always wins.
  always_comb begin
    grant_c = req;
    if (req == 2'b11) begin
      grant_c = last_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance && (|req)) begin
      last_d = grant_c[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Sequences a shared ripple-carry adder between two requesters with a fixed settle window.
// Optional resp_zero output enabled by defining ADDSUB_ZERO_FLAG_EN.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PORT_CNT-1:0] req_valid,
  output logic [PORT_CNT-1:0] req_ready,
  input  logic                req_sub0,
  input  logic                req_sub1,
  input  logic [WIDTH-1:0]    req_a0,
  input  logic [WIDTH-1:0]    req_b0,
  input  logic [WIDTH-1:0]    req_a1,
  input  logic [WIDTH-1:0]    req_b1,
  output logic [WIDTH-1:0]    adder_a,
  output logic [WIDTH-1:0]    adder_b,
  output logic                adder_ci,
  input  logic [WIDTH-1:0]    adder_sum,
  input  logic                adder_co,
  input  logic                adder_ovf,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_id,
  output logic [WIDTH-1:0]    resp_sum,
  output logic                resp_co,
  output logic                resp_ovf,
`ifdef ADDSUB_ZERO_FLAG_EN
  output logic                resp_zero,
`endif
  output logic                busy
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt_q, gnt_d;
  logic [PORT_CNT-1:0] req_ready_q, req_ready_d;
  logic [WIDTH-1:0]    adder_a_q, adder_a_d;
  logic [WIDTH-1:0]    adder_b_q, adder_b_d;
  logic                adder_ci_q, adder_ci_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_id_q, resp_id_d;
  logic [WIDTH-1:0]    resp_sum_q, resp_sum_d;
  logic                resp_co_q, resp_co_d;
  logic                resp_ovf_q, resp_ovf_d;
  logic                busy_q, busy_d;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic                resp_zero_q, resp_zero_d;
`endif

  logic [PORT_CNT-1:0] grant_c;
  logic                is_idle_c;
  logic                sel_sub_c;
  logic [WIDTH-1:0]    sel_a_c;
  logic [WIDTH-1:0]    sel_b_c;

  assign is_idle_c = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (reset_n),
    .req     (req_valid),
    .advance (is_idle_c),
    .grant_c (grant_c)
  );

  // Operand mux follows the arbiter's choice.
  assign sel_sub_c = grant_c[1] ? req_sub1 : req_sub0;
  assign sel_a_c   = grant_c[1] ? req_a1   : req_a0;
  assign sel_b_c   = grant_c[1] ? req_b1   : req_b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_valid)      state_d = SETTLE;
      SETTLE:  if (cnt_q == '0)     state_d = RESP;
      RESP:    if (resp_ready)      state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Adder inputs and response registers hold unless this state explicitly updates them.
  always_comb begin
    req_ready_d  = '0;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    adder_a_d    = adder_a_q;
    adder_b_d    = adder_b_q;
    adder_ci_d   = adder_ci_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_co_d    = resp_co_q;
    resp_ovf_d   = resp_ovf_q;
`ifdef ADDSUB_ZERO_FLAG_EN
    resp_zero_d  = resp_zero_q;
`endif
    busy_d       = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready_d = grant_c;
          gnt_d       = grant_c[1];
          cnt_d       = SETTLE_LOAD;
          adder_a_d   = sel_a_c;
          adder_b_d   = sel_sub_c ? ~sel_b_c : sel_b_c;
          adder_ci_d  = sel_sub_c;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          resp_valid_d = 1'b1;
          resp_id_d    = gnt_q;
          resp_sum_d   = adder_sum;
          resp_co_d    = adder_co;
          resp_ovf_d   = adder_ovf;
`ifdef ADDSUB_ZERO_FLAG_EN
          resp_zero_d  = (adder_sum == '0);
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready_q  <= '0;
      cnt_q        <= '0;
      gnt_q        <= 1'b0;
      adder_a_q    <= '0;
      adder_b_q    <= '0;
      adder_ci_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_sum_q   <= '0;
      resp_co_q    <= 1'b0;
      resp_ovf_q   <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
      resp_zero_q  <= 1'b0;
`endif
      busy_q       <= 1'b0;
    end else begin
      req_ready_q  <= req_ready_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      adder_a_q    <= adder_a_d;
      adder_b_q    <= adder_b_d;
      adder_ci_q   <= adder_ci_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_co_q    <= resp_co_d;
      resp_ovf_q   <= resp_ovf_d;
`ifdef ADDSUB_ZERO_FLAG_EN
      resp_zero_q  <= resp_zero_d;
`endif
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign adder_a    = adder_a_q;
  assign adder_b    = adder_b_q;
  assign adder_ci   = adder_ci_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_co    = resp_co_q;
  assign resp_ovf   = resp_ovf_q;
`ifdef ADDSUB_ZERO_FLAG_EN
  assign resp_zero  = resp_zero_q;
`endif
  assign busy       = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a transaction-level reference model and per-cycle checks.
module tb_addsub_arbiter;

  localparam int unsigned W        = 32;
  localparam int unsigned SETTLE_N = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic          req_sub0, req_sub1;
  logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
  logic [W-1:0]  adder_a, adder_b, adder_sum;
  logic          adder_ci, adder_co, adder_ovf;
  logic          resp_valid, resp_ready, resp_id, resp_co, resp_ovf, busy;
  logic [W-1:0]  resp_sum;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic          resp_zero;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(W), .SETTLE_CYCLES(SETTLE_N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sub0   (req_sub0),
    .req_sub1   (req_sub1),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_ci   (adder_ci),
    .adder_sum  (adder_sum),
    .adder_co   (adder_co),
    .adder_ovf  (adder_ovf),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_co    (resp_co),
    .resp_ovf   (resp_ovf),
`ifdef ADDSUB_ZERO_FLAG_EN
    .resp_zero  (resp_zero),
`endif
    .busy       (busy)
  );

  add32Bit u_adder (
    .a   (adder_a),
    .b   (adder_b),
    .ci  (adder_ci),
    .sum (adder_sum),
    .co  (adder_co),
    .ovf (adder_ovf)
  );

  typedef struct {
    logic        id;
    logic [31:0] a_drv;
    logic [31:0] b_drv;
    logic        ci;
    logic [31:0] sum;
    logic        co;
    logic        ovf;
    logic        zero;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: 33-bit sum plus sign-rule overflow.
  function automatic exp_t model_op(input logic id, input logic sub, input logic [31:0] a,
                                    input logic [31:0] b);
    exp_t        e;
    logic [32:0] t;
    e.id    = id;
    e.a_drv = a;
    e.b_drv = sub ? ~b : b;
    e.ci    = sub;
    t       = {1'b0, a} + {1'b0, e.b_drv} + 33'(sub);
    e.sum   = t[31:0];
    e.co    = t[32];
    e.ovf   = (a[31] == e.b_drv[31]) && (e.sum[31] != a[31]);
    e.zero  = (e.sum == 32'd0);
    return e;
  endfunction

  exp_t        q[$];
  logic        inflight_m, last_m, hs_prev;
  int          lat_m;
  logic [1:0]  snap_v;
  logic        snap_sub0, snap_sub1;
  logic [31:0] snap_a0, snap_b0, snap_a1, snap_b1;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_id", resp_id, 0);
      chk("rst_resp_sum", resp_sum, 0);
      chk("rst_resp_co_ovf", {resp_co, resp_ovf}, 0);
      chk("rst_adder", {adder_a, adder_b, adder_ci}, 0);
      chk("rst_busy", busy, 0);
      q.delete();
      inflight_m = 1'b0;
      last_m     = 1'b1;
      lat_m      = 0;
      snap_v     = 2'b00;
      hs_prev    = 1'b0;
    end else begin
      if (req_ready != 2'b00) begin : grant_chk
        logic p;
        p = (snap_v == 2'b11) ? ~last_m : (snap_v == 2'b10);
        chk("grant_had_request", |snap_v, 1);
        chk("grant_only_when_idle", inflight_m, 0);
        chk("grant_port", req_ready, p ? 2'b10 : 2'b01);
        q.push_back(model_op(p, p ? snap_sub1 : snap_sub0, p ? snap_a1 : snap_a0,
                             p ? snap_b1 : snap_b0));
        last_m     = p;
        inflight_m = 1'b1;
        lat_m      = 0;
      end
      if (hs_prev) begin
        if (q.size() > 0) void'(q.pop_front());
        inflight_m = 1'b0;
      end
      chk("busy", busy, inflight_m);
      chk("resp_valid_timing", resp_valid, inflight_m && (lat_m >= int'(SETTLE_N)));
      if (inflight_m && q.size() > 0) begin
        chk("adder_a", adder_a, q[0].a_drv);
        chk("adder_b", adder_b, q[0].b_drv);
        chk("adder_ci", adder_ci, q[0].ci);
      end
      if (resp_valid && q.size() > 0) begin
        chk("resp_id", resp_id, q[0].id);
        chk("resp_sum", resp_sum, q[0].sum);
        chk("resp_co", resp_co, q[0].co);
        chk("resp_ovf", resp_ovf, q[0].ovf);
`ifdef ADDSUB_ZERO_FLAG_EN
        chk("resp_zero", resp_zero, q[0].zero);
`endif
      end
      if (inflight_m) lat_m++;
      hs_prev   = resp_valid & resp_ready;
      snap_v    = req_valid;
      snap_sub0 = req_sub0;
      snap_sub1 = req_sub1;
      snap_a0   = req_a0;
      snap_b0   = req_b0;
      snap_a1   = req_a1;
      snap_b1   = req_b1;
    end
  end

  task automatic drive_port(input int port, input logic sub, input logic [31:0] a,
                            input logic [31:0] b);
    if (port == 0) begin
      req_sub0 = sub; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
    end else begin
      req_sub1 = sub; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
    end
  endtask

  task automatic wait_grant(input int port);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[port] && n < 50);
    chk($sformatf("grant_seen_p%0d", port), req_ready[port], 1);
  endtask

  task automatic issue(input int port, input logic sub, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    drive_port(port, sub, a, b);
    wait_grant(port);
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input logic id, input logic [31:0] sum,
                           input logic co, input logic ovf, input logic zero);
    int n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, resp_valid, 1);
    chk({tag, "_id"}, resp_id, id);
    chk({tag, "_sum"}, resp_sum, sum);
    chk({tag, "_co"}, resp_co, co);
    chk({tag, "_ovf"}, resp_ovf, ovf);
    chk({tag, "_sum_is_zero"}, resp_sum == 32'd0, zero);
`ifdef ADDSUB_ZERO_FLAG_EN
    chk({tag, "_zero"}, resp_zero, zero);
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    logic       order [4];
    int         ng, cyc;
    reset_n    = 1'b0;
    req_valid  = 2'b00;
    req_sub0   = 1'b0; req_sub1 = 1'b0;
    req_a0     = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    issue(0, 1'b0, 32'h7777_7777, 32'hBBBB_BBBB);
    wait_resp("add_p0", 1'b0, 32'h3333_3332, 1'b1, 1'b0, 1'b0);
    wait_idle();

    issue(1, 1'b1, 32'd5, 32'd7);
    @(negedge clk);
    chk("sub_adder_b", adder_b, 32'hFFFF_FFF8);
    chk("sub_adder_ci", adder_ci, 1);
    wait_resp("sub_p1", 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    wait_idle();

    issue(0, 1'b0, 32'h7FFF_FFFF, 32'd1);
    wait_resp("ovf_add", 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    wait_idle();
    issue(1, 1'b1, 32'h8000_0000, 32'd1);
    wait_resp("ovf_sub", 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    wait_idle();

    issue(1, 1'b1, 32'd9, 32'd9);
    wait_resp("zero_sub", 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Both ports held valid across four operations.
    @(posedge clk); #1;
    drive_port(0, 1'b0, 32'd100, 32'd30);
    drive_port(1, 1'b1, 32'd100, 32'd30);
    ng  = 0;
    cyc = 0;
    while (ng < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (req_ready != 2'b00) begin
        order[ng] = req_ready[1];
        ng++;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("contention_grant_count", ng, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("contention_order_%0d", i), order[i], i % 2);
    wait_idle();

    // Backpressure with a competing request parked on port 1.
    @(posedge clk); #1 resp_ready = 1'b0;
    issue(0, 1'b0, 32'd1, 32'd2);
    wait_resp("bp_first", 1'b0, 32'd3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_port(1, 1'b0, 32'd40, 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_sum", resp_sum, 32'd3);
      chk("bp_hold_busy", busy, 1);
      chk("bp_no_grant", req_ready, 2'b00);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_before_edge", resp_valid, 1);
    @(negedge clk);
    chk("bp_valid_dropped", resp_valid, 0);
    chk("bp_no_same_cycle_grant", req_ready, 2'b00);
    @(negedge clk);
    chk("bp_next_grant", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_resp("bp_second", 1'b1, 32'd42, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Asynchronous reset in the middle of a settle window.
    issue(1, 1'b0, 32'd10, 32'd20);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_adder", {adder_a, adder_b, adder_ci}, 0);
    chk("async_rst_resp", {resp_valid, resp_id, resp_sum, resp_co, resp_ovf}, 0);
    chk("async_rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_resp", resp_valid, 0);
    end
    @(posedge clk); #1;
    drive_port(0, 1'b0, 32'd6, 32'd7);
    drive_port(1, 1'b0, 32'd8, 32'd9);
    g   = 2'b00;
    cyc = 0;
    while (g == 2'b00 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      g = req_ready;
    end
    chk("post_rst_first_grant", g, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_resp("post_rst_resp", 1'b0, 32'd13, 1'b0, 1'b0, 1'b0);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Sequences the shared 32-bit ripple-carry adder (add32Bit) between two requesters (port 0, port 1).
- Arbitrates round-robin and converts subtract to add-with-inverted-B and carry-in 1.
- Holds adder inputs stable for a fixed settle window to cover gate-level ripple delay, then captures sum/carry/overflow.
- Returns the captured result to the granted requester over a valid/ready response channel.

Parameters:
- WIDTH, 32, operand/result width; must match the adder instance.
- SETTLE_CYCLES, 4, clock cycles adder inputs are held before capture; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-port request valid; bit i = port i.
- req_ready  output  2  per-port accept; bit i pulses for one cycle on grant.
- req_sub0, req_sub1  input  1 each  1 = A-B, 0 = A+B.
- req_a0, req_b0, req_a1, req_b1  input  WIDTH each  operands.
- adder_a, adder_b  output  WIDTH  drive shared adder a/b.
- adder_ci  output  1  drive adder carry-in.
- adder_sum  input  WIDTH  adder sum.
- adder_co, adder_ovf  input  1 each  adder carryout / overflow.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  1  port index the result belongs to.
- resp_sum  output  WIDTH  captured sum.
- resp_co, resp_ovf  output  1 each  captured carryout / overflow.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, reset_n low): state IDLE; req_ready=0, resp_valid=0, resp_id=0, resp_sum=0, resp_co=0, resp_ovf=0, adder_a=0, adder_b=0, adder_ci=0, busy=0, settle counter=0, last-grant pointer=1 (so port 0 wins first).
- States:
  - IDLE: if any req_valid, grant per round-robin. Register operands:
    - adder_a = A.
    - adder_b = sub ? ~B : B.
    - adder_ci = sub.
  - On grant, pulse req_ready[grant] for exactly that cycle, load counter with SETTLE_CYCLES-1, update pointer, and go to SETTLE.
  - SETTLE: adder_* held constant. Counter decrements each cycle. When counter==0, capture adder_sum/co/ovf into resp_* registers, set resp_valid=1 and resp_id=grant, and go to RESP.
  - RESP: resp_* held stable while resp_valid=1 and resp_ready=0. When resp_ready=1, clear resp_valid on the next edge and go to IDLE. There is no same-cycle re-grant.
- Latency: grant edge to resp_valid = SETTLE_CYCLES cycles. Minimum request-to-request spacing is SETTLE_CYCLES+2 cycles.
- Arbitration:
  - With both valid, the grant goes to the port not granted last.
  - With one valid, it is granted regardless of pointer.
  - The pointer updates only on grant.
- Requests are sampled only in IDLE. req_valid dropping during SETTLE/RESP has no effect on the in-flight operation.
- adder_* retain their last value in IDLE/RESP; they are not cleared.
- Arithmetic: subtract is two's complement, A + ~B + 1. The carryout/overflow semantics are the adder's: ovf = co[31]^co[32].
- Reset mid-operation aborts immediately. No response is issued for the aborted request.
- SETTLE_CYCLES=1: capture on the first SETTLE cycle.

Optional Feature:
- Macro ADDSUB_ZERO_FLAG_EN.
- Defined: adds output resp_zero (1 bit). It is registered together with resp_sum and equals (adder_sum==0) at capture. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package addsub_pkg holds:
  - state enum {IDLE, SETTLE, RESP} (2-bit).
  - the DEFAULT_SETTLE=4 constant.
  - the PORT_CNT=2 constant.
- One natural sub-module, rr_arb2: 2-input round-robin arbiter (req[1:0], pointer in, grant one-hot out, combinational). The arbiter owns the pointer register; the FSM remains in addsub_arbiter.
- The adder itself stays outside; the bench instantiates add32Bit and wires it to the adder_* ports.

Test Plan:
- Single add, port 0: a=32'h77777777, b=32'hBBBBBBBB, sub=0, resp_ready=1 -> resp_sum=32'h33333332, resp_co=1, resp_ovf=0, resp_id=0, resp_valid exactly SETTLE_CYCLES cycles after grant.
- Subtract, port 1: a=5, b=7, sub=1 -> adder_b=32'hFFFFFFF8, adder_ci=1, resp_sum=32'hFFFFFFFE, resp_co=0, resp_ovf=0, resp_id=1.
- Overflow: a=32'h7FFFFFFF, b=1, add -> resp_sum=32'h80000000, resp_ovf=1, resp_co=0. Also a=32'h80000000, b=1, sub -> resp_sum=32'h7FFFFFFF, resp_ovf=1, resp_co=1.
- Contention: both req_valid held high for 4 operations -> grants alternate 0,1,0,1. Each req_ready is a single-cycle pulse, and resp_id follows the grant order.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_* stable, busy=1, no new req_ready. resp_ready=1 -> next grant no earlier than one cycle after resp_valid falls.
- Async reset asserted mid-SETTLE -> all outputs 0 immediately. No resp_valid after release. Next simultaneous request is granted to port 0.
- With ADDSUB_ZERO_FLAG_EN: a=9, b=9, sub=1 -> resp_sum=0, resp_zero=1, resp_co=1.
